// File: rtl/sum_accumulator_if.sv
// Handshake bundle between the adder stage, the accumulator and the output mux.
// slave is the accumulator's view; master is the producer/consumer side.
interface sum_accumulator_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] sum_in;
  logic              carry_in;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              sat;

  modport slave (
    input  sum_in, carry_in, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last, sat
  );

  modport master (
    output sum_in, carry_in, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last, sat
  );
endinterface

// File: rtl/sum_accumulator.sv
// Accumulates COUNT adder results (sum plus carry) into a saturating register,
// then streams the total out byte-serially, LSB first, with last and sat flags.
module sum_accumulator #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int COUNT  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  sum_accumulator_if.slave bus
);

  localparam int NBYTES = ACC_W / DATA_W;
  localparam int CNT_W  = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  // One bit wider than the wider operand so overflow is always visible.
  localparam int SUM_W  = ((ACC_W > DATA_W + 1) ? ACC_W : DATA_W + 1) + 1;

  localparam logic [SUM_W-1:0] ACC_MAX  = {{(SUM_W - ACC_W){1'b0}}, {ACC_W{1'b1}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  typedef enum logic {ACCUM, EMIT} state_t;

  state_t             state, state_n;
  logic [ACC_W-1:0]   acc, acc_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic               sat_q, sat_n;

  logic [SUM_W-1:0]   term;
  logic [SUM_W-1:0]   sum_wide;
  logic               overflow;
  logic [DATA_W-1:0]  cur_byte;
  logic               is_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
      acc   <= '0;
      cnt   <= '0;
      idx   <= '0;
      sat_q <= 1'b0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      sat_q <= sat_n;
    end
  end

  assign term     = SUM_W'({bus.carry_in, bus.sum_in});
  assign sum_wide = SUM_W'(acc) + term;
  assign overflow = (sum_wide > ACC_MAX);

  // Byte selection uses a constant-indexed loop so any byte count lints cleanly.
  always_comb begin
    cur_byte = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_byte = acc[i*DATA_W +: DATA_W];
      end
    end
  end

  assign is_last = (idx == LAST_IDX);

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    idx_n   = idx;
    sat_n   = sat_q;

    if (clear) begin
      state_n = ACCUM;
      acc_n   = '0;
      cnt_n   = '0;
      idx_n   = '0;
      sat_n   = 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (bus.in_valid) begin
            if (overflow) begin
              acc_n = '1;
              sat_n = 1'b1;
            end else begin
              acc_n = sum_wide[ACC_W-1:0];
            end
            if (cnt == LAST_CNT) begin
              cnt_n   = '0;
              idx_n   = '0;
              state_n = EMIT;
            end else begin
              cnt_n = cnt + CNT_W'(1);
            end
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            if (is_last) begin
              acc_n   = '0;
              sat_n   = 1'b0;
              state_n = ACCUM;
            end else begin
              idx_n = idx + IDX_W'(1);
            end
          end
        end
        default: state_n = ACCUM;
      endcase
    end
  end

  // Outputs depend on registered state only, never on the handshake inputs.
  assign bus.in_ready  = (state == ACCUM);
  assign bus.out_valid = (state == EMIT);
  assign bus.out_last  = (state == EMIT) && is_last;
  assign bus.out_data  = (state == EMIT) ? cur_byte : '0;
  assign bus.sat       = sat_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed scoreboard bench: dut_a uses default parameters, dut_b uses
// ACC_W = 8, COUNT = 2 for single-byte saturation frames.
module tb_sum_accumulator;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear_a = 1'b0;
  logic clear_b = 1'b0;

  int total = 0;
  int bad = 0;

  exp_t exp_a[$];
  exp_t exp_b[$];
  exp_t ea;
  exp_t eb;

  sum_accumulator_if #(.DATA_W(8)) a_if ();
  sum_accumulator_if #(.DATA_W(8)) b_if ();

  sum_accumulator #(.DATA_W(8), .ACC_W(16), .COUNT(4)) dut_a (
    .clk   (clk),
    .rst   (rst),
    .clear (clear_a),
    .bus   (a_if.slave)
  );

  sum_accumulator #(.DATA_W(8), .ACC_W(8), .COUNT(2)) dut_b (
    .clk   (clk),
    .rst   (rst),
    .clear (clear_b),
    .bus   (b_if.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_in(input bit sel, input logic v, input logic c, input logic [7:0] s);
    if (sel) begin
      b_if.in_valid = v;
      b_if.carry_in = c;
      b_if.sum_in   = s;
    end else begin
      a_if.in_valid = v;
      a_if.carry_in = c;
      a_if.sum_in   = s;
    end
  endtask

  // One sample presented for one clock; consecutive calls are back-to-back.
  task automatic apply_stimulus(input bit sel, input logic c, input logic [7:0] s);
    drive_in(sel, 1'b1, c, s);
    @(posedge clk);
    #1;
    drive_in(sel, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic wait_drain(input bit sel, input string name);
    int left;
    for (int i = 0; i < 64; i++) begin
      left = sel ? exp_b.size() : exp_a.size();
      if (left == 0) break;
      @(posedge clk);
    end
    @(posedge clk);
    #1;
    left = sel ? exp_b.size() : exp_a.size();
    check_output(name, 16'(left), 16'd0);
  endtask

  task automatic push_a(input logic [7:0] d, input logic l, input logic s);
    exp_t e;
    e.data = d; e.last = l; e.sat = s;
    exp_a.push_back(e);
  endtask

  task automatic push_b(input logic [7:0] d, input logic l, input logic s);
    exp_t e;
    e.data = d; e.last = l; e.sat = s;
    exp_b.push_back(e);
  endtask

  // Monitors: a byte transfers at the coming edge whenever valid and ready are both high.
  always @(negedge clk) begin
    if (!rst && a_if.out_valid && a_if.out_ready) begin
      total++;
      if (exp_a.size() == 0) begin
        bad++;
        $display("[TB] FAIL a_unexpected_byte: got data 0x%0h last %0b, expected none",
                 a_if.out_data, a_if.out_last);
      end else begin
        ea = exp_a.pop_front();
        if ({a_if.out_data, a_if.out_last, a_if.sat} !== {ea.data, ea.last, ea.sat}) begin
          bad++;
          $display("[TB] FAIL a_byte: got data 0x%0h last %0b sat %0b, expected data 0x%0h last %0b sat %0b",
                   a_if.out_data, a_if.out_last, a_if.sat, ea.data, ea.last, ea.sat);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_if.out_valid && b_if.out_ready) begin
      total++;
      if (exp_b.size() == 0) begin
        bad++;
        $display("[TB] FAIL b_unexpected_byte: got data 0x%0h last %0b, expected none",
                 b_if.out_data, b_if.out_last);
      end else begin
        eb = exp_b.pop_front();
        if ({b_if.out_data, b_if.out_last, b_if.sat} !== {eb.data, eb.last, eb.sat}) begin
          bad++;
          $display("[TB] FAIL b_byte: got data 0x%0h last %0b sat %0b, expected data 0x%0h last %0b sat %0b",
                   b_if.out_data, b_if.out_last, b_if.sat, eb.data, eb.last, eb.sat);
        end
      end
    end
  end

  initial begin
    drive_in(1'b0, 1'b1, 1'b0, 8'h55);
    drive_in(1'b1, 1'b1, 1'b0, 8'h55);
    a_if.out_ready = 1'b1;
    b_if.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    drive_in(1'b0, 1'b0, 1'b0, 8'h00);
    drive_in(1'b1, 1'b0, 1'b0, 8'h00);
    check_output("reset_in_ready", 16'(a_if.in_ready), 16'd1);
    check_output("reset_out_valid", 16'(a_if.out_valid), 16'd0);
    check_output("reset_out_data", 16'(a_if.out_data), 16'd0);
    check_output("reset_out_last", 16'(a_if.out_last), 16'd0);
    check_output("reset_sat", 16'(a_if.sat), 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    $display("[TB] reset released");

    // Partial frame, then asynchronous reset between edges.
    apply_stimulus(1'b0, 1'b0, 8'h50);
    apply_stimulus(1'b0, 1'b0, 8'h50);
    #3;
    rst = 1'b1;
    #1;
    check_output("midreset_out_valid", 16'(a_if.out_valid), 16'd0);
    check_output("midreset_sat", 16'(a_if.sat), 16'd0);
    check_output("midreset_in_ready", 16'(a_if.in_ready), 16'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic frame: 0x10+0x20+0x30+0x40 = 0x00A0.
    push_a(8'hA0, 1'b0, 1'b0);
    push_a(8'h00, 1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b0, 8'h10);
    apply_stimulus(1'b0, 1'b0, 8'h20);
    apply_stimulus(1'b0, 1'b0, 8'h30);
    check_output("three_samples_no_valid", 16'(a_if.out_valid), 16'd0);
    apply_stimulus(1'b0, 1'b0, 8'h40);
    check_output("basic_valid_k1", 16'(a_if.out_valid), 16'd1);
    check_output("basic_last_byte0", 16'(a_if.out_last), 16'd0);
    @(posedge clk);
    #1;
    check_output("basic_valid_byte1", 16'(a_if.out_valid), 16'd1);
    check_output("basic_last_byte1", 16'(a_if.out_last), 16'd1);
    wait_drain(1'b0, "basic_drain");

    // Carry path: 4 x 0x1FF = 2044 = 0x07FC; in_ready low exactly two cycles.
    push_a(8'hFC, 1'b0, 1'b0);
    push_a(8'h07, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 1'b1, 8'hFF);
    check_output("carry_in_ready_c1", 16'(a_if.in_ready), 16'd0);
    @(posedge clk);
    #1;
    check_output("carry_in_ready_c2", 16'(a_if.in_ready), 16'd0);
    @(posedge clk);
    #1;
    check_output("carry_in_ready_c3", 16'(a_if.in_ready), 16'd1);
    check_output("carry_out_valid_c3", 16'(a_if.out_valid), 16'd0);
    wait_drain(1'b0, "carry_drain");

    // Backpressure: hold out_ready low, pulse in_valid, byte must stay put.
    a_if.out_ready = 1'b0;
    push_a(8'hFC, 1'b0, 1'b0);
    push_a(8'h07, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 1'b1, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      drive_in(1'b0, 1'b1, 1'b0, 8'h11);
      check_output("bp_out_data", 16'(a_if.out_data), 16'h00FC);
      check_output("bp_out_valid", 16'(a_if.out_valid), 16'd1);
      check_output("bp_in_ready", 16'(a_if.in_ready), 16'd0);
      @(posedge clk);
      #1;
    end
    drive_in(1'b0, 1'b0, 1'b0, 8'h00);
    a_if.out_ready = 1'b1;
    wait_drain(1'b0, "bp_drain");

    // Saturation on the 8-bit instance: 0xFF + 0x02 clamps to 0xFF.
    push_b(8'hFF, 1'b1, 1'b1);
    apply_stimulus(1'b1, 1'b0, 8'hFF);
    apply_stimulus(1'b1, 1'b0, 8'h02);
    check_output("sat_flag", 16'(b_if.sat), 16'd1);
    check_output("sat_last", 16'(b_if.out_last), 16'd1);
    wait_drain(1'b1, "sat_drain");
    check_output("sat_cleared_after_frame", 16'(b_if.sat), 16'd0);
    push_b(8'h02, 1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b0, 8'h01);
    apply_stimulus(1'b1, 1'b0, 8'h01);
    wait_drain(1'b1, "sat_next_drain");

    // Clear after the low byte: 4 x 0x80 = 0x0200, high byte abandoned.
    a_if.out_ready = 1'b0;
    push_a(8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 1'b0, 8'h80);
    a_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    a_if.out_ready = 1'b0;
    clear_a = 1'b1;
    @(posedge clk);
    #1;
    clear_a = 1'b0;
    check_output("clear_out_valid", 16'(a_if.out_valid), 16'd0);
    check_output("clear_in_ready", 16'(a_if.in_ready), 16'd1);
    check_output("clear_out_data", 16'(a_if.out_data), 16'd0);
    a_if.out_ready = 1'b1;
    push_a(8'h04, 1'b0, 1'b0);
    push_a(8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 1'b0, 8'h01);
    wait_drain(1'b0, "clear_next_drain");

    // Asynchronous reset while the 8-bit instance is emitting a saturated byte.
    b_if.out_ready = 1'b0;
    apply_stimulus(1'b1, 1'b0, 8'hFF);
    apply_stimulus(1'b1, 1'b0, 8'h02);
    check_output("emit_before_reset_valid", 16'(b_if.out_valid), 16'd1);
    #3;
    rst = 1'b1;
    #1;
    check_output("emit_reset_out_valid", 16'(b_if.out_valid), 16'd0);
    check_output("emit_reset_sat", 16'(b_if.sat), 16'd0);
    check_output("emit_reset_in_ready", 16'(b_if.in_ready), 16'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    b_if.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
